quadrature_tx: RTL and testbench



---
 rtl/quadrature_tx.sv | 195 +++++++++++++++++++
 tb/tb_quadrature_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_tx.sv
// Quadrature A/B waveform generator driven by step commands, with optional
// contact-bounce injection on the changing output of each transition.
module quadrature_tx #(
    parameter int STEP_WIDTH  = 8,
    parameter int PHASE_WIDTH = 8,
    parameter int BOUNCE_N    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_dir,
    input  logic [STEP_WIDTH-1:0]  cmd_steps,
    input  logic [PHASE_WIDTH-1:0] cmd_phase,
    input  logic                   cmd_bounce,
    output logic                   enc_a,
    output logic                   enc_b,
    output logic                   busy,
    output logic                   done,
    output logic [STEP_WIDTH-1:0]  position,
    output logic [1:0]             dbg_state
);

    // Handshake: a command transfers on a rising clk edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is only high in IDLE, and the command
    // fields are sampled on that edge and ignored afterwards.

    localparam int BW = (BOUNCE_N > 1) ? $clog2(2 * BOUNCE_N - 1) : 1;
    localparam logic [BW-1:0] GLITCHES = BW'(2 * BOUNCE_N - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   a_q, a_d;
    logic                   b_q, b_d;
    logic [STEP_WIDTH-1:0]  pos_q, pos_d;
    logic                   dir_q, dir_d;
    logic                   bounce_q, bounce_d;
    logic [STEP_WIDTH-1:0]  steps_q, steps_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]             idx_q, idx_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic                   bsel_q, bsel_d;
    logic [1:0]             ab_old, ab_new;

    // Clean {A,B} level after idx transitions of the current step.
    function automatic logic [1:0] gray_ab(input logic [1:0] idx, input logic dir);
        logic [1:0] ab;
        case (idx)
            2'd0:    ab = 2'b00;
            2'd1:    ab = dir ? 2'b10 : 2'b01;
            2'd2:    ab = 2'b11;
            default: ab = dir ? 2'b01 : 2'b10;
        endcase
        return ab;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            bounce_q <= 1'b0;
            steps_q  <= '0;
            phase_q  <= PHASE_WIDTH'(1);
            cnt_q    <= '0;
            idx_q    <= '0;
            bcnt_q   <= '0;
            bsel_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            a_q      <= a_d;
            b_q      <= b_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            bounce_q <= bounce_d;
            steps_q  <= steps_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            bcnt_q   <= bcnt_d;
            bsel_q   <= bsel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        a_d      = a_q;
        b_d      = b_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        bounce_d = bounce_q;
        steps_d  = steps_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        bcnt_d   = bcnt_q;
        bsel_d   = bsel_q;
        ab_old   = gray_ab(idx_q, dir_q);
        ab_new   = gray_ab(idx_q + 2'd1, dir_q);

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (cmd_valid && ready_q) begin
                    dir_d    = cmd_dir;
                    bounce_d = cmd_bounce;
                    steps_d  = cmd_steps;
                    phase_d  = (cmd_phase == '0) ? PHASE_WIDTH'(1) : cmd_phase;
                    cnt_d    = (cmd_phase == '0) ? PHASE_WIDTH'(1) : cmd_phase;
                    idx_d    = '0;
                    bcnt_d   = '0;
                    ready_d  = 1'b0;
                    if (cmd_steps == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end

            RUN: begin
                if (cnt_q <= PHASE_WIDTH'(1)) begin
                    // A transition overrides any glitches still pending.
                    cnt_d  = phase_q;
                    idx_d  = idx_q + 2'd1;
                    a_d    = ab_new[1];
                    b_d    = ab_new[0];
                    bsel_d = (ab_new[1] == ab_old[1]);
                    bcnt_d = bounce_q ? GLITCHES : '0;
                    if (idx_q == 2'd3) begin
                        pos_d   = dir_q ? pos_q + STEP_WIDTH'(1) : pos_q - STEP_WIDTH'(1);
                        steps_d = steps_q - STEP_WIDTH'(1);
                        if (steps_q == STEP_WIDTH'(1)) begin
                            state_d = FINISH;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            bcnt_d  = '0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - PHASE_WIDTH'(1);
                    if (bcnt_q != '0) begin
                        if (bsel_q) b_d = ~b_q;
                        else        a_d = ~a_q;
                        bcnt_d = bcnt_q - BW'(1);
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign enc_a     = a_q;
    assign enc_b     = b_q;
    assign position  = pos_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_quadrature_tx.sv
// Bench for quadrature_tx: directed and random commands compared cycle by
// cycle against a waveform model derived from step/phase arithmetic.
module tb_quadrature_tx;
  localparam int SW = 8;
  localparam int PW = 8;
  localparam int BN = 3;
  localparam int EW = SW + 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [SW-1:0] cmd_steps;
  logic [PW-1:0] cmd_phase;
  logic          cmd_bounce;
  logic          enc_a;
  logic          enc_b;
  logic          busy;
  logic          done;
  logic [SW-1:0] position;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle {ready, busy, done, a, b, position}.
  logic [EW-1:0] exp_q[$];
  logic [SW-1:0] model_pos;

  logic          nxt_dir;
  logic [SW-1:0] nxt_steps;
  logic [PW-1:0] nxt_phase;
  logic          nxt_bounce;

  quadrature_tx #(
    .STEP_WIDTH(SW),
    .PHASE_WIDTH(PW),
    .BOUNCE_N(BN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps),
    .cmd_phase(cmd_phase),
    .cmd_bounce(cmd_bounce),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .busy(busy),
    .done(done),
    .position(position),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // {A,B} after m transitions of a command.
  function automatic logic [1:0] seq_ab(input logic dir, input int m);
    logic [1:0] inc_tab[4];
    logic [1:0] dec_tab[4];
    inc_tab = '{2'b00, 2'b10, 2'b11, 2'b01};
    dec_tab = '{2'b00, 2'b01, 2'b11, 2'b10};
    return dir ? inc_tab[m % 4] : dec_tab[m % 4];
  endfunction

  // Offset k counts edges from the handshake edge (k=0).
  task automatic build_model(input logic dir, input int steps, input int phase, input logic bounce);
    int p;
    int len;
    p   = (phase == 0) ? 1 : phase;
    len = 4 * steps * p;
    for (int k = 0; k <= len + 1; k++) begin
      logic          rdy;
      logic          bsy;
      logic          dn;
      logic [1:0]    ab;
      logic [SW-1:0] pos;
      int            m;
      int            r;
      if (k == len) begin
        rdy = 1'b0; bsy = 1'b0; dn = 1'b1; m = 4 * steps;
      end else if (k == len + 1) begin
        rdy = 1'b1; bsy = 1'b0; dn = 1'b0; m = 4 * steps;
      end else begin
        rdy = 1'b0; bsy = 1'b1; dn = 1'b0; m = k / p;
      end
      ab  = seq_ab(dir, m);
      pos = dir ? model_pos + SW'(m / 4) : model_pos - SW'(m / 4);
      if (k < len && bounce && m >= 1) begin
        r = k % p;
        if (r >= 1 && r <= 2 * BN - 2 && (r % 2) == 1) ab = seq_ab(dir, m - 1);
      end
      exp_q.push_back({rdy, bsy, dn, ab, pos});
    end
    model_pos = dir ? model_pos + SW'(steps) : model_pos - SW'(steps);
  endtask

  task automatic run_cmd(input logic d, input logic [SW-1:0] s, input logic [PW-1:0] p,
                         input logic b, input bit hold_next);
    logic [EW-1:0] e;
    @(negedge clk);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = s;
    cmd_phase  = p;
    cmd_bounce = b;
    build_model(d, int'(s), int'(p), b);
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("cmd_ready", cmd_ready, e[EW-1]);
      check("busy", busy, e[EW-2]);
      check("done", done, e[EW-3]);
      check("enc_a", enc_a, e[SW+1]);
      check("enc_b", enc_b, e[SW]);
      check("position", position, e[SW-1:0]);
      if (exp_q.size() > 0) begin
        @(negedge clk);
        if (hold_next) begin
          cmd_valid  = 1'b1;
          cmd_dir    = nxt_dir;
          cmd_steps  = nxt_steps;
          cmd_phase  = nxt_phase;
          cmd_bounce = nxt_bounce;
        end else begin
          cmd_valid  = 1'($urandom_range(0, 1));
          cmd_dir    = 1'($urandom_range(0, 1));
          cmd_steps  = SW'($urandom_range(0, 255));
          cmd_phase  = PW'($urandom_range(0, 255));
          cmd_bounce = 1'($urandom_range(0, 1));
        end
      end
    end
    cmd_valid = hold_next;
  endtask

  task automatic pick_next();
    nxt_dir    = 1'($urandom_range(0, 1));
    nxt_steps  = SW'($urandom_range(0, 4));
    nxt_phase  = PW'($urandom_range(0, 8));
    nxt_bounce = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic          cur_dir;
    logic [SW-1:0] cur_steps;
    logic [PW-1:0] cur_phase;
    logic          cur_bounce;
    bit            hold;

    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'b0;
    cmd_steps  = '0;
    cmd_phase  = '0;
    cmd_bounce = 1'b0;
    model_pos  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_enc_a", enc_a, 0);
    check("rst_enc_b", enc_b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_position", position, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("idle_outputs", {enc_a, enc_b, cmd_ready, busy, done, position},
            {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    end

    run_cmd(1'b1, 8'd2, 8'd4, 1'b0, 1'b0);
    run_cmd(1'b0, 8'd3, 8'd0, 1'b0, 1'b0);
    run_cmd(1'b1, 8'd1, 8'd10, 1'b1, 1'b0);

    nxt_dir = 1'b0; nxt_steps = 8'd2; nxt_phase = 8'd3; nxt_bounce = 1'b1;
    run_cmd(1'b1, 8'd2, 8'd2, 1'b0, 1'b1);
    run_cmd(nxt_dir, nxt_steps, nxt_phase, nxt_bounce, 1'b0);
    run_cmd(1'b1, 8'd0, 8'd5, 1'b0, 1'b0);

    pick_next();
    for (int i = 0; i < 30; i++) begin
      cur_dir = nxt_dir; cur_steps = nxt_steps; cur_phase = nxt_phase; cur_bounce = nxt_bounce;
      pick_next();
      hold = 1'($urandom_range(0, 1));
      run_cmd(cur_dir, cur_steps, cur_phase, cur_bounce, hold);
    end

    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd5; cmd_phase = 8'd3; cmd_bounce = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_enc_a", enc_a, 0);
    check("abort_enc_b", enc_b, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_position", position, 0);
    model_pos = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", done, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    run_cmd(1'b1, 8'd1, 8'd2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
